// File: rtl/pc_unit.sv
// Program-counter unit: prioritised next-pc selection (trap, mret, redirect,
// RAS pop, stall, increment), trap return address and a circular return-address stack.
module pc_unit #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int                STEP         = 4,
  parameter int                ALIGN_BITS   = 2,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call,
  input  logic            ret,
  input  logic            trap_req,
  input  logic            mret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic            ret_miss,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int                PW         = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int                CW         = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0]   STEP_X     = XLEN'(STEP);
  localparam logic [XLEN-1:0]   ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [CW-1:0]     DEPTH_C    = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    ACT_TRAP,
    ACT_MRET,
    ACT_MISALIGN,
    ACT_REDIRECT,
    ACT_POP,
    ACT_RET_MISS,
    ACT_HOLD,
    ACT_STEP
  } action_e;

  action_e         act;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misaligned_q, misaligned_d;
  logic            ret_miss_q, ret_miss_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   top_ptr;
  logic [XLEN-1:0] pc_plus_w;
  logic            push;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];

  assign pc_plus_w = pc_q + STEP_X;
  // ptr_q names the next slot to write; the most recent push sits one below it.
  assign top_ptr   = ptr_q - PW'(1);

  always_comb begin
    act = ACT_STEP;
    if (trap_req)            act = ACT_TRAP;
    else if (mret)           act = ACT_MRET;
    else if (redirect_valid) act = ((redirect_target & ALIGN_MASK) != '0) ? ACT_MISALIGN : ACT_REDIRECT;
    else if (ret && !stall)  act = (cnt_q != '0) ? ACT_POP : ACT_RET_MISS;
    else if (stall)          act = ACT_HOLD;
  end

  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    misaligned_d = 1'b0;
    ret_miss_d   = 1'b0;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    push         = 1'b0;
    unique case (act)
      ACT_TRAP, ACT_MISALIGN: begin
        pc_d         = TRAP_VECTOR;
        epc_d        = pc_q;
        cnt_d        = '0;
        misaligned_d = (act == ACT_MISALIGN);
      end
      ACT_MRET: pc_d = epc_q;
      ACT_REDIRECT: begin
        pc_d = redirect_target;
        if (call) begin
          // When full the write lands on the oldest slot, so count saturates.
          push  = 1'b1;
          ptr_d = ptr_q + PW'(1);
          if (cnt_q != DEPTH_C) cnt_d = cnt_q + CW'(1);
        end
      end
      ACT_POP: begin
        pc_d  = ras_mem[top_ptr];
        ptr_d = top_ptr;
        cnt_d = cnt_q - CW'(1);
      end
      ACT_RET_MISS: begin
        pc_d       = pc_plus_w;
        ret_miss_d = 1'b1;
      end
      ACT_HOLD: pc_d = pc_q;
      default:  pc_d = pc_plus_w;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      misaligned_q <= 1'b0;
      ret_miss_q   <= 1'b0;
      ptr_q        <= '0;
      cnt_q        <= '0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      misaligned_q <= misaligned_d;
      ret_miss_q   <= ret_miss_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_mem[ptr_q] <= pc_plus_w;
  end

  assign pc         = pc_q;
  assign pc_plus    = pc_plus_w;
  assign epc        = epc_q;
  assign misaligned = misaligned_q;
  assign ret_miss   = ret_miss_q;
  assign ras_empty  = (cnt_q == '0);
  assign ras_full   = (cnt_q == DEPTH_C);

endmodule
